instr_fetch_unit: RTL and testbench

- Fetch-side initiator for the combinational instruction ROM.
- Owns the program counter, drives the byte address to the ROM, and captures the returned word each cycle.
- Buffers fetched words in a small queue and hands {pc, instruction} pairs to the decode stage over a valid/ready handshake.
- Supports branch redirect (flush plus new PC) and halts fetching at the end of the program window.

---
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and ROM fetcher feeding decode through a small {pc, instr} queue; `define FETCH_PERF_COUNTERS_EN adds fetch_count/stall_cycles. Ports: clk, reset, pc/instruction (ROM), redirect_valid/redirect_pc, fetch_stall, dec_valid/dec_ready/dec_instr/dec_pc (decode), halted, queue_count.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_LIMIT = 32'd32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic fetch_stall,
  output logic dec_valid,
  input  logic dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic halted,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
`endif
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'd3;
  typedef enum logic [1:0] {RUN, STALLED, HALT} state_t;
  state_t state, state_next;
  logic [31:0] fetch_pc, pc_next, redirect_pc_a, hold_instr, hold_pc;
  logic [31:0] q_instr [QUEUE_DEPTH];
  logic [31:0] q_pc [QUEUE_DEPTH];
  logic [AW-1:0] head, tail;
  logic pop, push, full;
  assign pc = fetch_pc;
  assign redirect_pc_a = redirect_pc & ~32'd3;
  assign full = queue_count == CW'(QUEUE_DEPTH);
  assign dec_valid = queue_count != '0;
  assign pop = dec_valid & dec_ready;
  assign push = !redirect_valid & !fetch_stall & !halted & (!full | pop);
  assign pc_next = redirect_valid ? redirect_pc_a : push ? fetch_pc + 32'd4 : fetch_pc;
  // With the queue empty the outputs replay last cycle's values instead of stale slots.
  assign dec_instr = dec_valid ? q_instr[head] : hold_instr;
  assign dec_pc = dec_valid ? q_pc[head] : hold_pc;
  always_ff @(posedge clk) begin
    if (reset) state <= (RESET_PC_A >= PC_LIMIT) ? HALT : RUN;
    else state <= state_next;
  end
  // HALT tracks pc_next >= PC_LIMIT, so halted always matches the registered fetch_pc.
  always_comb begin
    state_next = redirect_valid ? ((redirect_pc_a >= PC_LIMIT) ? HALT : RUN)
               : (pc_next >= PC_LIMIT) ? HALT
               : (fetch_stall | (full & !pop)) ? STALLED : RUN;
  end
  always_comb begin
    halted = state == HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC_A;
      head <= '0;
      tail <= '0;
      queue_count <= '0;
      hold_instr <= '0;
      hold_pc <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i] <= '0;
      end
    end else begin
      fetch_pc <= pc_next;
      hold_instr <= dec_instr;
      hold_pc <= dec_pc;
      if (redirect_valid) begin
        head <= '0;
        tail <= '0;
        queue_count <= '0;
      end else begin
        if (push) begin
          q_instr[tail] <= instruction;
          q_pc[tail] <= fetch_pc;
          tail <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        queue_count <= queue_count + CW'(push) - CW'(pop);
      end
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_cycles <= '0;
    end else begin
      if (push && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if (!halted && !push && !redirect_valid && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit with PC_LIMIT=16.
module tb_instr_fetch_unit;
  logic clk = 0, reset = 1;
  logic [31:0] pc, instruction, redirect_pc = 0, dec_instr, dec_pc;
  logic redirect_valid = 0, fetch_stall = 0, dec_valid, dec_ready = 1, halted;
  logic [1:0] queue_count;
  int checks = 0, failures = 0;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count, stall_cycles, stall_base;
`endif
  instr_fetch_unit #(.RESET_PC(32'd0), .PC_LIMIT(32'd16), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_stall(fetch_stall),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .halted(halted), .queue_count(queue_count)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fetch_count), .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  assign instruction = 32'h0004_1800 + ({28'd0, pc[5:2]} << 16);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic rdy);
    reset = 1;
    redirect_valid = 0;
    fetch_stall = 0;
    dec_ready = rdy;
    tick();
    reset = 0;
  endtask
  initial begin
    do_reset(1);
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_pc", pc, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(queue_count), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", 32'(dec_valid), 1);
      chk("stream_pc", dec_pc, 32'(i * 4));
      chk("stream_instr", dec_instr, 32'h0004_1800 + (32'(i) << 16));
      chk("stream_count", 32'(queue_count), 1);
    end
    chk("limit_halted", 32'(halted), 1);
    chk("limit_pc", pc, 16);
    tick();
    chk("drained_valid", 32'(dec_valid), 0);
    chk("drained_count", 32'(queue_count), 0);
    do_reset(0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_count", 32'(queue_count), 2);
    chk("bp_pc", pc, 8);
    chk("bp_dec_pc", dec_pc, 0);
    chk("bp_dec_instr", dec_instr, 32'h0004_1800);
    dec_ready = 1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("bp_drain_pc", dec_pc, 32'(i * 4));
      chk("bp_drain_instr", dec_instr, 32'h0004_1800 + (32'(i) << 16));
      chk("bp_drain_count", 32'(queue_count), (i < 3) ? 2 : 1);
    end
    tick();
    chk("bp_empty", 32'(dec_valid), 0);
    do_reset(0);
    tick();
    tick();
    chk("rd_pre_count", 32'(queue_count), 2);
    redirect_valid = 1;
    redirect_pc = 32'h0000_0006;
    tick();
    chk("rd_valid", 32'(dec_valid), 0);
    chk("rd_pc", pc, 4);
    chk("rd_count", 32'(queue_count), 0);
    redirect_valid = 0;
    dec_ready = 1;
    tick();
    chk("rd_dec_pc", dec_pc, 4);
    chk("rd_dec_instr", dec_instr, 32'h0005_1800);
    redirect_valid = 1;
    redirect_pc = 32'd32;
    tick();
    chk("rd32_halted", 32'(halted), 1);
    chk("rd32_count", 32'(queue_count), 0);
    redirect_pc = 32'd0;
    tick();
    chk("rd0_halted", 32'(halted), 0);
    chk("rd0_pc", pc, 0);
    redirect_valid = 0;
    tick();
    chk("rd0_valid", 32'(dec_valid), 1);
    chk("rd0_dec_pc", dec_pc, 0);
    do_reset(0);
    tick();
    tick();
    fetch_stall = 1;
    dec_ready = 1;
`ifdef FETCH_PERF_COUNTERS_EN
    stall_base = stall_cycles;
`endif
    tick();
    chk("st_count1", 32'(queue_count), 1);
    chk("st_pc1", pc, 8);
    tick();
    chk("st_valid", 32'(dec_valid), 0);
    tick();
    chk("st_pc3", pc, 8);
    chk("st_count3", 32'(queue_count), 0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("st_perf", stall_cycles - stall_base, 3);
`endif
    fetch_stall = 0;
    tick();
    chk("st_resume_pc", dec_pc, 8);
    reset = 1;
    tick();
    chk("mr_valid", 32'(dec_valid), 0);
    chk("mr_pc", pc, 0);
    chk("mr_dec_pc", dec_pc, 0);
    chk("mr_dec_instr", dec_instr, 0);
    chk("mr_count", 32'(queue_count), 0);
    chk("mr_halted", 32'(halted), 0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("mr_perf", stall_cycles, 0);
    chk("mr_fetches", fetch_count, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
